half_subtractor: RTL and testbench

// - Registered WIDTH-bit subtractor: diff = a - b (mod 2^WIDTH), borrow = (a < b) unsigned.
// - WIDTH=1 gives the classic half subtractor: diff = a ^ b, borrow = ~a & b.
// - Leaf arithmetic block for datapaths; one clock domain, one-cycle latency, no backpressure.

---
 rtl/half_sub_pkg.sv | 21 ++
 rtl/full_subtractor_cell.sv | 13 +
 rtl/half_subtractor.sv | 81 ++++++++
 tb/tb_half_subtractor.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/half_sub_pkg.sv
// Shared constants and a behavioural reference for the registered half_subtractor.
package half_sub_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam int DEFAULT_CNT_W = 16;
  localparam int MAX_WIDTH     = 64;

  // Returns {borrow, diff}; diff is masked to the low 'width' bits.
  function automatic logic [64:0] sub_ref(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int          width = DEFAULT_WIDTH);
    logic [63:0] mask;
    logic [63:0] am;
    logic [63:0] bm;
    mask = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    am   = a & mask;
    bm   = b & mask;
    return {(am < bm), ((am - bm) & mask)};
  endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor cell used for every bit above bit 0 of the borrow chain.
module full_subtractor_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/half_subtractor.sv
// Registered WIDTH-bit ripple-borrow subtractor with one-cycle latency.
// Optional saturating borrow counter is enabled with `define HALF_SUB_STATS_EN.
module half_subtractor
  import half_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             out_valid
`ifdef HALF_SUB_STATS_EN
  ,
  output logic [CNT_W-1:0] borrow_count
`endif
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH || CNT_W < 1) begin : g_badParams
    $error("half_subtractor: WIDTH must be 1..64 and CNT_W at least 1");
  end

  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_brw;

  assign w_diff[0] = a[0] ^ b[0];
  assign w_brw[0]  = ~a[0] & b[0];

  for (genvar gi = 1; gi < WIDTH; gi++) begin : g_cell
    full_subtractor_cell u_cell (
      .x    (a[gi]),
      .y    (b[gi]),
      .bin  (w_brw[gi-1]),
      .d    (w_diff[gi]),
      .bout (w_brw[gi])
    );
  end

  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_outValid;

  // Results only load on a valid sample so they hold steady while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_diff     <= '0;
      r_borrow   <= 1'b0;
      r_outValid <= 1'b0;
    end else begin
      r_outValid <= in_valid;
      if (in_valid) begin
        r_diff   <= w_diff;
        r_borrow <= w_brw[WIDTH-1];
      end
    end
  end

  assign diff      = r_diff;
  assign borrow    = r_borrow;
  assign out_valid = r_outValid;

`ifdef HALF_SUB_STATS_EN
  logic [CNT_W-1:0] r_borrowCount;

  // Saturates at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_borrowCount <= '0;
    end else if (in_valid && w_brw[WIDTH-1] && (r_borrowCount != {CNT_W{1'b1}})) begin
      r_borrowCount <= r_borrowCount + CNT_W'(1);
    end
  end

  assign borrow_count = r_borrowCount;
`endif

endmodule

// File: tb/tb_half_subtractor.sv
// Self-checking bench for half_subtractor at WIDTH 1, 8 and 16 (CNT_W=2 on the 16-bit copy).
// Borrow-counter checks are active when HALF_SUB_STATS_EN is defined.
module tb_half_subtractor;

  logic        clk;
  logic        rst_n;

  logic        a1, b1, v1, d1, br1, ov1;
  logic [7:0]  a8, b8, d8;
  logic        v8, br8, ov8;
  logic [15:0] a16, b16, d16;
  logic        v16, br16, ov16;
`ifdef HALF_SUB_STATS_EN
  logic [15:0] cnt1;
  logic [15:0] cnt8;
  logic [1:0]  cnt16;
`endif

  int compareCount  = 0;
  int mismatchCount = 0;

  logic [15:0] expDiff   [3];
  logic        expBorrow [3];
  logic        expValid  [3];
  int          expCount  [3];
  int          satCount  [3];

  half_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1),
    .diff(d1), .borrow(br1), .out_valid(ov1)
`ifdef HALF_SUB_STATS_EN
    , .borrow_count(cnt1)
`endif
  );

  half_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(v8),
    .diff(d8), .borrow(br8), .out_valid(ov8)
`ifdef HALF_SUB_STATS_EN
    , .borrow_count(cnt8)
`endif
  );

  half_subtractor #(.WIDTH(16), .CNT_W(2)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .in_valid(v16),
    .diff(d16), .borrow(br16), .out_valid(ov16)
`ifdef HALF_SUB_STATS_EN
    , .borrow_count(cnt16)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < 3; i++) begin
      expDiff[i]   = '0;
      expBorrow[i] = 1'b0;
      expValid[i]  = 1'b0;
      expCount[i]  = 0;
    end
  endtask

  task automatic compareInstance(input int sel, input string tag);
    logic [15:0] obsDiff;
    logic        obsBorrow;
    logic        obsValid;
    int          obsCount;
    obsCount = expCount[sel];
    case (sel)
      0: begin obsDiff = {15'd0, d1}; obsBorrow = br1;  obsValid = ov1;  end
      1: begin obsDiff = {8'd0, d8};  obsBorrow = br8;  obsValid = ov8;  end
      default: begin obsDiff = d16;   obsBorrow = br16; obsValid = ov16; end
    endcase
`ifdef HALF_SUB_STATS_EN
    case (sel)
      0:       obsCount = int'(cnt1);
      1:       obsCount = int'(cnt8);
      default: obsCount = int'(cnt16);
    endcase
    checkOutput({tag, " count"}, 64'(obsCount), 64'(expCount[sel]));
`endif
    checkOutput({tag, " out_valid"}, 64'(obsValid),  64'(expValid[sel]));
    checkOutput({tag, " diff"},      64'(obsDiff),   64'(expDiff[sel]));
    checkOutput({tag, " borrow"},    64'(obsBorrow), 64'(expBorrow[sel]));
  endtask

  // Drives one instance for one edge; the other instances see in_valid=0.
  task automatic applyStimulus(input int sel, input logic [15:0] a, input logic [15:0] b,
                               input logic v, input string tag);
    int          w;
    int unsigned mask;
    int unsigned am;
    int unsigned bm;
    w  = (sel == 0) ? 1 : ((sel == 1) ? 8 : 16);
    v1 = 1'b0; v8 = 1'b0; v16 = 1'b0;
    case (sel)
      0: begin a1 = a[0];   b1 = b[0];   v1 = v;  end
      1: begin a8 = a[7:0]; b8 = b[7:0]; v8 = v;  end
      default: begin a16 = a; b16 = b;  v16 = v; end
    endcase
    @(posedge clk);
    #1;
    mask = (32'd1 << w) - 32'd1;
    for (int i = 0; i < 3; i++) expValid[i] = 1'b0;
    expValid[sel] = v;
    if (v) begin
      am = 32'(a) & mask;
      bm = 32'(b) & mask;
      expDiff[sel]   = 16'((am - bm) & mask);
      expBorrow[sel] = (am < bm);
      if (expBorrow[sel] && expCount[sel] < satCount[sel]) expCount[sel]++;
    end
    compareInstance(sel, tag);
  endtask

  initial begin
    satCount[0] = 65535;
    satCount[1] = 65535;
    satCount[2] = 3;
    resetModel();
    a1 = 0; b1 = 0; v1 = 0;
    a8 = 0; b8 = 0; v8 = 0;
    a16 = 0; b16 = 0; v16 = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) compareInstance(i, $sformatf("reset u%0d", i));
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] T1 width-1 truth table");
    applyStimulus(0, 16'd0, 16'd0, 1'b1, "T1 00");
    applyStimulus(0, 16'd1, 16'd0, 1'b1, "T1 10");
    applyStimulus(0, 16'd1, 16'd1, 1'b1, "T1 11");
    applyStimulus(0, 16'd0, 16'd1, 1'b1, "T1 01");

    $display("[TB] T2 width-8 vectors and 16-bit boundaries");
    applyStimulus(1, 16'h00, 16'h01, 1'b1, "T2 00-01");
    applyStimulus(1, 16'hA5, 16'h5A, 1'b1, "T2 A5-5A");
    applyStimulus(1, 16'h3C, 16'h3C, 1'b1, "T2 3C-3C");
    applyStimulus(2, 16'h0000, 16'hFFFF, 1'b1, "T2 0-max");
    applyStimulus(2, 16'hFFFF, 16'h0000, 1'b1, "T2 max-0");
    applyStimulus(2, 16'h8001, 16'h8001, 1'b1, "T2 eq");

    $display("[TB] T3 hold while idle");
    applyStimulus(1, 16'hA5, 16'h5A, 1'b1, "T3 load");
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 16'($urandom), 16'($urandom), 1'b0, $sformatf("T3 idle%0d", i));

    $display("[TB] T4 async reset mid-stream");
    applyStimulus(1, 16'h00, 16'h01, 1'b1, "T4 pre");
    v8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
    #2 rst_n = 1'b0;
    #1;
    resetModel();
    for (int i = 0; i < 3; i++) compareInstance(i, $sformatf("T4 async u%0d", i));
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 16'h77, 16'h01, 1'b0, "T4 idle0");
    applyStimulus(1, 16'h77, 16'h01, 1'b0, "T4 idle1");
    applyStimulus(1, 16'h77, 16'h01, 1'b1, "T4 first");

`ifdef HALF_SUB_STATS_EN
    $display("[TB] T5 borrow counter saturation");
    for (int i = 0; i < 5; i++)
      applyStimulus(2, 16'h0010, 16'h0020, 1'b1, $sformatf("T5 s%0d", i));
    checkOutput("T5 saturated", 64'(cnt16), 64'd3);
    #1 rst_n = 1'b0;
    #1;
    resetModel();
    checkOutput("T5 reset", 64'(cnt16), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("[TB] T6 random width-16");
    for (int i = 0; i < 1000; i++)
      applyStimulus(2, 16'($urandom), 16'($urandom), ($urandom_range(3) != 0), "T6 rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
